// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch and data access.
// The data port wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err,
    output logic        stall
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACCESS_IF = 2'd1;
    localparam logic [1:0] ST_ACCESS_DM = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    localparam int CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TMR_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int PORT_IF = 0;
    localparam int PORT_DM = 1;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             mem_req_reg, mem_req_next;
    logic             mem_we_reg, mem_we_next;
    logic [31:0]      mem_addr_reg, mem_addr_next;
    logic [31:0]      mem_wdata_reg, mem_wdata_next;
    logic             err_reg, err_next;

    logic starved;
    logic grant_dm;
    logic grant_if;
    logic timed_out;

    // A waiting fetch that has already seen STARVE_LIMIT data grants takes the slot.
    assign starved   = if_req && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    assign grant_dm  = dm_req && !starved;
    assign grant_if  = if_req && !grant_dm;
    assign timed_out = (timer_reg == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        timer_next      = timer_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        err_next        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_dm) begin
                    state_next     = ST_ACCESS_DM;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    timer_next     = '0;
                    if (!if_req)
                        starve_cnt_next = '0;
                    else if (starve_cnt_reg != CNT_W'(STARVE_LIMIT))
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                end else if (grant_if) begin
                    state_next      = ST_ACCESS_IF;
                    mem_req_next    = 1'b1;
                    mem_we_next     = 1'b0;
                    mem_addr_next   = if_addr;
                    mem_wdata_next  = '0;
                    timer_next      = '0;
                    starve_cnt_next = '0;
                end
            end
            ST_ACCESS_IF, ST_ACCESS_DM: begin
                // A ready arriving in the expiry cycle still counts as success.
                if (mem_ready || timed_out) begin
                    state_next   = ST_RESP;
                    mem_req_next = 1'b0;
                    err_next     = !mem_ready;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            starve_cnt_reg <= '0;
            timer_reg      <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            timer_reg      <= timer_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            err_reg        <= err_next;
        end
    end

    // Per-requester completion: ack pulse and read data owned by whichever port holds the transfer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic [1:0] ACC_ST = (gi == PORT_DM) ? ST_ACCESS_DM : ST_ACCESS_IF;
            logic        done;
            logic        ack_reg;
            logic [31:0] rdata_reg;

            assign done = (state_reg == ACC_ST) && (mem_ready || timed_out);

            always_ff @(posedge clk) begin
                if (reset) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= done;
                    if (done)
                        rdata_reg <= (mem_ready && !mem_we_reg) ? mem_rdata : '0;
                end
            end
        end
    endgenerate

    assign if_ack    = g_port[PORT_IF].ack_reg;
    assign if_rdata  = g_port[PORT_IF].rdata_reg;
    assign dm_ack    = g_port[PORT_DM].ack_reg;
    assign dm_rdata  = g_port[PORT_DM].rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign err       = err_reg;
    assign stall     = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs checked on the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, err, stall;
    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        vectors++; if ({mem_req, mem_we, if_ack, dm_ack, err, stall} !== 6'b0) begin miscompares++; $display("FAIL reset_ctrl got %b exp 000000", {mem_req, mem_we, if_ack, dm_ack, err, stall}); end
        vectors++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin miscompares++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: outputs idle");
    endtask

    task automatic test_fetch_min_latency();
        if_req = 1; if_addr = 32'h10;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c0 got %b exp 1", stall); end
        @(negedge clk);
        vectors++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin miscompares++; $display("FAIL fetch_grant got req=%b we=%b addr=%h exp 1 0 00000010", mem_req, mem_we, mem_addr); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c1 got %b exp 1", stall); end
        mem_ready = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        vectors++; if ({if_ack, dm_ack, err, mem_req} !== 4'b1000) begin miscompares++; $display("FAIL fetch_ack got %b exp 1000", {if_ack, dm_ack, err, mem_req}); end
        vectors++; if (if_rdata !== 32'h12345678) begin miscompares++; $display("FAIL fetch_rdata got %h exp 12345678", if_rdata); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_c2 got %b exp 0", stall); end
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        vectors++; if (if_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_ack_pulse got %b exp 0", if_ack); end
        $display("fetch: addr 0x10 returned %h", if_rdata);
    endtask

    task automatic test_dm_priority();
        if_req = 1; if_addr = 32'h80;
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h40, 32'hDEADBEEF}) begin miscompares++; $display("FAIL prio_dm_grant got req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ready = 1; mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        vectors++; if ({dm_ack, if_ack, err} !== 3'b100) begin miscompares++; $display("FAIL prio_dm_ack got %b exp 100", {dm_ack, if_ack, err}); end
        vectors++; if (dm_rdata !== 32'h0) begin miscompares++; $display("FAIL prio_store_rdata got %h exp 00000000", dm_rdata); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL prio_stall got %b exp 1", stall); end
        dm_req = 0; mem_ready = 0;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL prio_idle got %b exp 0", mem_req); end
        @(negedge clk);
        vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h80, 32'h0}) begin miscompares++; $display("FAIL prio_if_grant got req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        vectors++; if ({if_ack, dm_ack, if_rdata} !== {2'b10, 32'hCAFEF00D}) begin miscompares++; $display("FAIL prio_if_ack got ack=%b%b rdata=%h exp 10 cafef00d", if_ack, dm_ack, if_rdata); end
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        $display("priority: store then fetch served");
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr;
        if_req = 1; if_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            dm_req = 1; dm_we = 0; dm_addr = 32'h200 + 32'(k);
            exp_addr = (k < 4) ? 32'h200 + 32'(k) : 32'h100;
            @(negedge clk);
            vectors++; if (mem_addr !== exp_addr) begin miscompares++; $display("FAIL starve_grant%0d got %h exp %h", k, mem_addr, exp_addr); end
            if (k == 4) begin
                vectors++; if (dut.starve_cnt_reg !== '0) begin miscompares++; $display("FAIL starve_cnt_clear got %0d exp 0", dut.starve_cnt_reg); end
            end
            mem_ready = 1; mem_rdata = 32'(k);
            @(negedge clk);
            vectors++; if ({dm_ack, if_ack} !== ((k < 4) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL starve_ack%0d got dm=%b if=%b", k, dm_ack, if_ack); end
            dm_req = 0; mem_ready = 0;
            if (k == 4) if_req = 0;
            @(negedge clk);
            $display("starvation: round %0d served addr %h", k, exp_addr);
        end
    endtask

    task automatic test_ready_last_cycle();
        dm_req = 1; dm_we = 0; dm_addr = 32'h310;
        @(negedge clk);
        repeat (15) @(negedge clk);
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL last_cycle_req got %b exp 1", mem_req); end
        mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        vectors++; if ({dm_ack, err, dm_rdata} !== {2'b10, 32'h5A5A5A5A}) begin miscompares++; $display("FAIL last_cycle_ack got ack=%b err=%b rdata=%h exp 1 0 5a5a5a5a", dm_ack, err, dm_rdata); end
        dm_req = 0; mem_ready = 0;
        @(negedge clk);
        $display("ready in final timeout cycle: rdata %h", dm_rdata);
    endtask

    task automatic test_timeout();
        int n;
        dm_req = 1; dm_we = 0; dm_addr = 32'h320;
        n = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && n < 40) begin n++; @(negedge clk); end
        vectors++; if (n != 16) begin miscompares++; $display("FAIL timeout_len got %0d exp 16", n); end
        vectors++; if ({dm_ack, if_ack, err, dm_rdata} !== {3'b101, 32'h0}) begin miscompares++; $display("FAIL timeout_resp got ack=%b%b err=%b rdata=%h exp 10 1 0", dm_ack, if_ack, err, dm_rdata); end
        dm_req = 0;
        @(negedge clk);
        vectors++; if ({dm_ack, err} !== 2'b00) begin miscompares++; $display("FAIL timeout_pulse got %b exp 00", {dm_ack, err}); end
        $display("timeout: mem_req held %0d cycles", n);
    endtask

    task automatic test_mid_reset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h330; dm_wdata = 32'h11;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL midrst_grant got %b exp 1", mem_req); end
        reset = 1;
        @(negedge clk);
        vectors++; if ({mem_req, mem_we, dm_ack, err} !== 4'b0000) begin miscompares++; $display("FAIL midrst_abort got %b exp 0000", {mem_req, mem_we, dm_ack, err}); end
        reset = 0; dm_req = 0;
        repeat (2) @(negedge clk);
        vectors++; if ({mem_req, dm_ack} !== 2'b00) begin miscompares++; $display("FAIL midrst_noack got %b exp 00", {mem_req, dm_ack}); end
        if_req = 1; if_addr = 32'h20;
        @(negedge clk);
        vectors++; if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin miscompares++; $display("FAIL midrst_fetch_grant got req=%b addr=%h exp 1 00000020", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h77;
        @(negedge clk);
        vectors++; if ({if_ack, if_rdata} !== {1'b1, 32'h77}) begin miscompares++; $display("FAIL midrst_fetch_ack got ack=%b rdata=%h exp 1 00000077", if_ack, if_rdata); end
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        $display("mid-transfer reset: abandoned, fetch served");
    endtask

    initial begin
        test_reset();
        test_fetch_min_latency();
        test_dm_priority();
        test_starvation();
        test_ready_last_cycle();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage pipeline.
- Arbitrates between the two requesters, sequences each transfer over a variable-latency memory handshake, and returns the read data.
- Drives a stall signal that the hazard logic uses to freeze PC and the pipeline registers while an access is pending.
- Data port has priority; a starvation counter guarantees instruction-fetch progress.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants allowed while if_req is waiting.
- TIMEOUT, 16: cycles to wait for mem_ready before abandoning a transfer.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- if_req  in  1  instruction fetch request; held until if_ack.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_req  out  1  memory request; held until mem_ready or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- err  out  1  pulses with the ack of a timed-out transfer.
- stall  out  1  pipeline freeze.

Behaviour:
- Reset values: state=IDLE; mem_req, mem_we, if_ack, dm_ack and err = 0; all data/address outputs = 0; starve_cnt=0; timer=0.
- Reset mid-transfer: the transfer is abandoned, no ack is issued, and IDLE is entered at the next edge.
- All outputs except stall are registered. stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
- Four states: IDLE, ACCESS_IF, ACCESS_DM, RESP.
- IDLE, request sampling:
  - Grant DM if dm_req=1, unless (if_req=1 and starve_cnt==STARVE_LIMIT); in that case grant IF.
  - Otherwise grant IF if if_req=1. With no request, stay in IDLE.
- IDLE, on grant: latch address, we and wdata into mem_* (if grant: we=0, wdata=0), set mem_req=1, clear timer, and enter ACCESS_IF or ACCESS_DM.
- starve_cnt update at grant time:
  - DM grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - DM grant with if_req=0, or any IF grant: clear to 0.
- ACCESS_x: hold mem_* stable; increment the timer every cycle.
  - On mem_ready=1: capture mem_rdata into the owner's rdata register (a store returns 0), drop mem_req, and go to RESP with the owner's ack pulsed.
  - If the timer reaches TIMEOUT-1 without mem_ready: drop mem_req, go to RESP with ack=1, err=1 and rdata=0.
- RESP: ack and err are high for exactly this one cycle; no sampling; the next state is IDLE. Requesters deassert req on the edge after ack; a req still high in the following IDLE cycle is treated as a new request.
- Minimum latency: req sampled in IDLE at cycle 0 → mem_req=1 in cycle 1 → mem_ready in cycle 1 → ack in cycle 2.
- Only one ack is issued per transfer. if_ack and dm_ack are never high together. Inputs are ignored outside IDLE; a requester changing its address mid-transfer has no effect.
- A mem_ready arriving in the same cycle as the timeout expiry is treated as success: err=0 and the data is captured.

Test Plan:
- Reset, then if_req=1 with if_addr=0x10, mem_ready one cycle after mem_req → mem_addr=0x10, mem_we=0; if_ack at cycle 2 with if_rdata=mem_rdata; stall=1 in cycles 0-1.
- if_req and dm_req both high, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF → DM granted first (mem_we=1, mem_wdata=0xDEADBEEF, dm_ack, dm_rdata=0); IF is granted in the next IDLE.
- if_req held high while dm_req is re-raised after every ack → exactly 4 DM grants, then one IF grant, after which starve_cnt=0.
- mem_ready is never asserted → mem_req drops after 16 cycles; the owner's ack, err=1 and rdata=0 appear in the same cycle.
- reset asserted while in ACCESS_DM → next edge: mem_req=0, no dm_ack; a fresh if_req is served normally afterwards.
- mem_ready asserted in the final timeout cycle → ack with err=0 and the captured data.
